// File: rtl/clk_div_swt.sv
// Purpose: glitch-free programmable clock divider; ratio changes apply only at an output-period boundary.
// Latency: capture-to-ack is 1 cycle from STOP, 1..P_old cycles from RUN; clk_out/clk_en are flop outputs.
// Backpressure: busy covers capture through the ack cycle; div_req seen while busy is dropped, not queued.
module clk_div_swt #(
    parameter int          DIV_W   = 8,
    parameter int unsigned RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_out,
    output logic             clk_en
);

    // One extra counter bit so the largest code gives P = 2^DIV_W without wrap.
    localparam int CW = DIV_W + 1;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] RST_CODE  = DIV_W'(RST_DIV);
    localparam state_t           RST_STATE = (RST_CODE != '0) ? ST_RUN : ST_STOP;
    // Parking the counter at P-1 makes the first edge after reset a period start.
    localparam logic [CW-1:0]    RST_CNT   = {1'b0, RST_CODE};

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] cur_q, cur_d;
    logic             pend_vld_q, pend_vld_d;
    logic             ack_q, ack_d;
    logic             out_q, out_d;
    logic             en_q, en_d;

    logic [CW-1:0]    per;
    logic [CW-1:0]    last;
    logic [CW-1:0]    high;
    logic             capture;
    logic             switch_now;

    assign per  = {1'b0, cur_q} + CW'(1);
    assign last = per - CW'(1);
    // ceil(P/2) without needing a wider adder.
    assign high = (per >> 1) + CW'(per[0]);

    // busy stays up through the ack cycle, so a request on that edge is also ignored.
    assign busy       = pend_vld_q | ack_q;
    assign capture    = div_req & ~busy;
    // Only a pending request can switch; the capture edge never qualifies since pend_vld_q is still 0.
    assign switch_now = pend_vld_q & ((state_q == ST_STOP) | (cnt_q == last));

    assign div_ack = ack_q;
    assign cur_div = cur_q;
    assign clk_out = out_q;
    assign clk_en  = en_q;

    // Next-state: ratio switch at period boundary, request capture, free-running period counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cur_d      = cur_q;
        ack_d      = 1'b0;
        out_d      = 1'b0;
        en_d       = 1'b0;

        if (switch_now) begin
            cur_d      = pend_q;
            ack_d      = 1'b1;
            pend_vld_d = 1'b0;
            cnt_d      = '0;
            if (pend_q != '0) begin
                state_d = ST_RUN;
                out_d   = 1'b1;
                en_d    = 1'b1;
            end else begin
                state_d = ST_STOP;
            end
        end else begin
            if (capture) begin
                pend_d     = div_val;
                pend_vld_d = 1'b1;
            end
            if (state_q == ST_RUN) begin
                cnt_d = (cnt_q == last) ? '0 : cnt_q + CW'(1);
                out_d = (cnt_d < high);
                en_d  = (cnt_d == '0);
            end else begin
                cnt_d = '0;
            end
        end
    end

    // State and output registers; reset drops any pending request without an ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RST_STATE;
            cnt_q      <= RST_CNT;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cur_q      <= RST_CODE;
            ack_q      <= 1'b0;
            out_q      <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cur_q      <= cur_d;
            ack_q      <= ack_d;
            out_q      <= out_d;
            en_q       <= en_d;
        end
    end

endmodule

// File: tb/tb_clk_div_swt.sv
// Purpose: self-checking bench for clk_div_swt against a period/position reference model.
// Latency: model advances on each posedge, outputs compared on each negedge.
// Backpressure: stimulus holds div_req across busy windows to exercise the drop behaviour.
module tb_clk_div_swt;

    localparam int DIV_W   = 8;
    localparam int RST_DIV = 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             div_req = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             div_ack;
    logic             busy;
    logic [DIV_W-1:0] cur_div;
    logic             clk_out;
    logic             clk_en;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: current period, position in the period, pending request.
    bit m_run;
    int m_per;
    int m_pos;
    int m_cur;
    int m_pend;
    bit m_pv;
    bit m_ack;

    clk_div_swt #(.DIV_W(DIV_W), .RST_DIV(RST_DIV)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .busy    (busy),
        .cur_div (cur_div),
        .clk_out (clk_out),
        .clk_en  (clk_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur  = RST_DIV;
        m_per  = RST_DIV + 1;
        m_run  = (RST_DIV != 0);
        m_pos  = m_run ? m_per - 1 : 0;
        m_pend = 0;
        m_pv   = 1'b0;
        m_ack  = 1'b0;
    endtask

    task automatic model_step(input bit req, input int val);
        bit bsy;
        bsy = m_pv || m_ack;
        if (m_pv && (!m_run || m_pos == m_per - 1)) begin
            m_cur = m_pend;
            m_ack = 1'b1;
            m_pv  = 1'b0;
            m_pos = 0;
            m_run = (m_pend != 0);
            if (m_run) m_per = m_pend + 1;
        end else begin
            m_ack = 1'b0;
            if (req && !bsy) begin
                m_pend = val;
                m_pv   = 1'b1;
            end
            if (m_run) m_pos = (m_pos + 1) % m_per;
        end
    endtask

    function automatic int exp_out();
        return int'(m_run && (m_pos < (m_per + 1) / 2));
    endfunction

    function automatic int exp_en();
        return int'(m_run && m_pos == 0);
    endfunction

    // Model update on every active edge or reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else       model_step(div_req, int'(div_val));
        end
    end

    // Compare process: all outputs against the model on every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && chk_en) begin
                chk("m_clk_out", int'(clk_out), exp_out());
                chk("m_clk_en",  int'(clk_en),  exp_en());
                chk("m_div_ack", int'(div_ack), int'(m_ack));
                chk("m_busy",    int'(busy),    int'(m_pv || m_ack));
                chk("m_cur_div", int'(cur_div), m_cur);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic req(input int v);
        div_req = 1'b1;
        div_val = DIV_W'(v);
        @(negedge clk);
        div_req = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        int n;
        n = 0;
        while (!div_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait", int'(div_ack), 1);
    endtask

    initial begin
        int acks;
        int hi;
        int first_low;
        int n;

        // Reset values.
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_clk_en",  int'(clk_en),  0);
        chk("rst_ack",     int'(div_ack), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_cur",     int'(cur_div), 1);
        #2 rstn = 1'b1;
        chk_en = 1'b1;

        // D=1 after release: 1,0,1,0 from the first edge.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rel_out", int'(clk_out), int'(i % 2 == 0));
            chk("rel_en",  int'(clk_en),  int'(i % 2 == 0));
            chk("rel_cur", int'(cur_div), 1);
        end

        // D=4 requested on a cnt=0 edge: one more low cycle, then ack with rising output.
        @(negedge clk);
        chk("d4_align_en", int'(clk_en), 1);
        div_req = 1'b1;
        div_val = DIV_W'(4);
        @(negedge clk);
        div_req = 1'b0;
        chk("d4_busy0", int'(busy), 1);
        chk("d4_ack0",  int'(div_ack), 0);
        chk("d4_out0",  int'(clk_out), 0);
        @(negedge clk);
        chk("d4_busy1", int'(busy), 1);
        chk("d4_ack1",  int'(div_ack), 1);
        chk("d4_out1",  int'(clk_out), 1);
        chk("d4_cur",   int'(cur_div), 4);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) chk("d4_busy_done", int'(busy), 0);
            chk("d4_pat", int'(clk_out), int'(i < 3));
        end

        // D=2: 1,1,0 repeating.
        req(2);
        wait_ack(20);
        for (int i = 0; i < 6; i++) begin
            chk("d2_pat", int'(clk_out), int'((i % 3) < 2));
            @(negedge clk);
        end

        // D=0: finish current period, then hold low.
        req(0);
        wait_ack(20);
        chk("d0_cur", int'(cur_div), 0);
        chk("d0_out", int'(clk_out), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("d0_hold_out", int'(clk_out), 0);
            chk("d0_hold_en",  int'(clk_en), 0);
        end

        // D=3 from STOP: ack on the edge after capture, then 1,1,0,0.
        div_req = 1'b1;
        div_val = DIV_W'(3);
        @(negedge clk);
        div_req = 1'b0;
        chk("d3_busy", int'(busy), 1);
        chk("d3_ack0", int'(div_ack), 0);
        chk("d3_out0", int'(clk_out), 0);
        @(negedge clk);
        chk("d3_ack1", int'(div_ack), 1);
        for (int i = 0; i < 8; i++) begin
            chk("d3_pat", int'(clk_out), int'((i % 4) < 2));
            @(negedge clk);
        end

        // Requests while busy and on the ack edge are dropped.
        div_req = 1'b1;
        div_val = DIV_W'(5);
        @(negedge clk);
        div_val = DIV_W'(7);
        n = 0;
        while (!div_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ign_ack_seen", int'(div_ack), 1);
        chk("ign_cur", int'(cur_div), 5);
        @(negedge clk);
        div_req = 1'b0;
        chk("ign_busy_after", int'(busy), 0);
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (div_ack) acks++;
        end
        chk("ign_extra_ack", acks, 0);
        chk("ign_cur_hold", int'(cur_div), 5);

        // Maximum code: 128 high, 128 low.
        req(255);
        wait_ack(20);
        hi = 0;
        first_low = -1;
        for (int i = 0; i < 256; i++) begin
            if (clk_out) hi++;
            else if (first_low < 0) first_low = i;
            @(negedge clk);
        end
        chk("max_high", hi, 128);
        chk("max_first_low", first_low, 128);
        chk("max_wrap_en", int'(clk_en), 1);
        chk("max_cur", int'(cur_div), 255);

        // Reset while busy: immediate clear, restart at the reset ratio, no ack.
        req(9);
        repeat (3) @(negedge clk);
        chk("rb_busy", int'(busy), 1);
        chk("rb_out_high", int'(clk_out), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rb_out", int'(clk_out), 0);
        chk("rb_busy_clr", int'(busy), 0);
        chk("rb_ack", int'(div_ack), 0);
        chk("rb_cur", int'(cur_div), 1);
        @(negedge clk);
        #2 rstn = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (div_ack) acks++;
            chk("rb_restart", int'(clk_out), int'(i % 2 == 0));
        end
        chk("rb_no_ack", acks, 0);

        // Random requests against the model, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                div_req = 1'b1;
                if ($urandom_range(0, 9) == 0) div_val = DIV_W'($urandom_range(0, 255));
                else                           div_val = DIV_W'($urandom_range(0, 6));
            end else begin
                div_req = 1'b0;
            end
            if (i == 1500) begin
                #2 rstn = 1'b0;
                @(negedge clk);
                #2 rstn = 1'b1;
            end
        end
        div_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
